// File: rtl/prng_range_sampler.sv
// Rejection sampler fed by an external 128-bit LFSR: shifts OUT_W fresh bits per
// candidate, masks to the next power of two above limit-1, and queues accepted values.
module prng_range_sampler #(
    parameter int OUT_W = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [OUT_W-1:0] limit,
    input  logic [127:0]     lfsr_q,
    output logic             lfsr_ce,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      reject_cnt,
    output logic             busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SC_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        EVAL  = 2'd2
    } state_t;

    // Ones up to and including the MSB of lim-1; zero limit means full range.
    function automatic logic [OUT_W-1:0] range_mask(input logic [OUT_W-1:0] lim);
        logic [OUT_W-1:0] m;
        if (lim == '0) begin
            m = '1;
        end else begin
            m = lim - OUT_W'(1);
            for (int i = 0; i < OUT_W; i++) begin
                m = m | (m >> 1);
            end
        end
        return m;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t           state_q, state_d;
    logic [SC_W-1:0]  shift_cnt_q, shift_cnt_d;
    logic [OUT_W-1:0] lim_q, lim_d;

    logic [OUT_W-1:0] cand_p0;
    logic             accept_p0;
    logic             vld_p0;
    logic             pop;

    logic [OUT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic [CNT_W-1:0] post_cnt;
    logic             has_room;

    logic [15:0]      rej_cnt;
    logic             unused_lfsr_hi;

    assign unused_lfsr_hi = ^lfsr_q[127:OUT_W];

    // Stage p0: candidate evaluation, valid only in EVAL
    assign cand_p0   = lfsr_q[OUT_W-1:0] & range_mask(lim_q);
    assign accept_p0 = (lim_q == '0) || (cand_p0 < lim_q);
    assign vld_p0    = (state_q == EVAL) && accept_p0;

    assign pop      = out_valid && out_ready;
    assign has_room = (fifo_cnt < CNT_W'(DEPTH));
    assign post_cnt = fifo_cnt + CNT_W'(1) - CNT_W'(pop);

    always_comb begin
        state_d     = state_q;
        shift_cnt_d = shift_cnt_q;
        lim_d       = lim_q;
        lfsr_ce     = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && has_room) begin
                    lim_d       = limit;
                    shift_cnt_d = '0;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                lfsr_ce = 1'b1;
                if (shift_cnt_q == SC_W'(OUT_W - 1)) begin
                    state_d = EVAL;
                end else begin
                    shift_cnt_d = shift_cnt_q + SC_W'(1);
                end
            end
            EVAL: begin
                shift_cnt_d = '0;
                if (accept_p0) begin
                    if (enable && (post_cnt < CNT_W'(DEPTH))) begin
                        lim_d   = limit;
                        state_d = SHIFT;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    // A started sample always runs to an accept, keeping its limit
                    state_d = SHIFT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_cnt_q <= '0;
            lim_q       <= '0;
        end else begin
            state_q     <= state_d;
            shift_cnt_q <= shift_cnt_d;
            lim_q       <= lim_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rej_cnt <= 16'd0;
        end else if ((state_q == EVAL) && !accept_p0) begin
            rej_cnt <= sat_inc(rej_cnt);
        end
    end

    // Stage p1: FIFO write of accepted candidate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (vld_p0) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({vld_p0, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (vld_p0) begin
            mem[wr_ptr] <= cand_p0;
        end
    end

    assign out_valid  = (fifo_cnt != '0);
    assign out_data   = out_valid ? mem[rd_ptr] : '0;
    assign reject_cnt = rej_cnt;
    assign busy       = (state_q != IDLE);

endmodule
